// File: rtl/stepper_ramp_drive_pkg.sv
// Shared definitions for the two-motor stepper ramp drive: command codes,
// FSM state encoding and the half-step coil table.
package stepper_ramp_drive_pkg;

  localparam logic [4:0] CMD_NONE     = 5'b00000;
  localparam logic [4:0] CMD_FORWARD  = 5'b00001;
  localparam logic [4:0] CMD_BACKWARD = 5'b00010;
  localparam logic [4:0] CMD_LEFT     = 5'b00100;
  localparam logic [4:0] CMD_RIGHT    = 5'b01000;
  localparam logic [4:0] CMD_STOP     = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEL  = 2'd1,
    ST_CRUISE = 2'd2,
    ST_DECEL  = 2'd3
  } state_t;

  // Coil pattern for each half-step index.
  function automatic logic [3:0] phase_of(input logic [2:0] idx);
    case (idx)
      3'd0: phase_of = 4'b1000;
      3'd1: phase_of = 4'b1100;
      3'd2: phase_of = 4'b0100;
      3'd3: phase_of = 4'b0110;
      3'd4: phase_of = 4'b0010;
      3'd5: phase_of = 4'b0011;
      3'd6: phase_of = 4'b0001;
      3'd7: phase_of = 4'b1001;
    endcase
  endfunction

  function automatic logic is_one_hot(input logic [4:0] c);
    return (c != 5'd0) && ((c & (c - 5'd1)) == 5'd0);
  endfunction

  function automatic logic is_move(input logic [4:0] c);
    return c inside {CMD_FORWARD, CMD_BACKWARD, CMD_LEFT, CMD_RIGHT};
  endfunction

  // Motor directions {d1, d0} for a movement command; 1 steps the index up.
  function automatic logic [1:0] dirs_of(input logic [4:0] c);
    case (c)
      CMD_FORWARD:  dirs_of = 2'b11;
      CMD_LEFT:     dirs_of = 2'b10;
      CMD_RIGHT:    dirs_of = 2'b01;
      default:      dirs_of = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/stepper_ramp_drive_halfstep_seq.sv
// Half-step sequencer for one unipolar motor: 3-bit index with wrap and a
// registered coil drive that is released when the motor is not running.
module halfstep_seq
  import stepper_ramp_drive_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       tick,
  input  logic       dir,
  output logic [3:0] phase
);

  logic [2:0] idx;
  logic [2:0] idx_next;

  // One half-step per tick; 3-bit arithmetic gives the 7<->0 wrap for free
  always_comb begin
    // NOTE: default first so every path assigns idx_next and no latch is inferred.
    idx_next = idx;
    if (tick) idx_next = dir ? idx + 3'd1 : idx - 3'd1;
  end

  // Index and coil register; coils show the index the motor is moving to
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      idx   <= 3'd0;
      phase <= 4'b0000;
    end else begin
      idx   <= idx_next;
      phase <= run ? phase_of(idx_next) : 4'b0000;
    end
  end

endmodule

// File: rtl/stepper_ramp_drive.sv
// Two-motor stepper drive with trapezoidal step-rate ramp, pending-command
// handling across deceleration, and a command watchdog.
module stepper_ramp_drive
  import stepper_ramp_drive_pkg::*;
#(
  parameter logic [15:0] P_START     = 16'd40000,
  parameter logic [15:0] P_MIN       = 16'd8000,
  parameter logic [15:0] P_DEC       = 16'd2000,
  parameter logic [23:0] WDOG_CYCLES = 24'd8000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [4:0] cmd,
  output logic [3:0] m0_phase,
  output logic [3:0] m1_phase,
  output logic       busy,
  output logic [1:0] state_o,
  output logic       cmd_err,
  output logic       wdog_trip
);

  state_t      state;
  logic [15:0] period;
  logic [15:0] timer;
  logic [4:0]  pending;
  logic [23:0] wdog_cnt;
  logic        d0;
  logic        d1;

  logic        accept;
  logic        cmd_bad;
  logic        cmd_is_move;
  logic [1:0]  cmd_dirs;
  logic        same_dir;
  logic        tick;
  logic [16:0] dec_wide;
  logic [16:0] inc_wide;
  logic [15:0] period_dn;
  logic [15:0] period_up;
  logic [15:0] period_run;
  logic        wdog_hit;
  logic [4:0]  pending_eff;
  logic        decel_done;
  logic        start_move;
  logic        run;

  // Command, timer, period-saturation and run decode for the FSM and sequencers
  always_comb begin
    accept      = cmd_valid && is_one_hot(cmd);
    cmd_bad     = cmd_valid && !is_one_hot(cmd);
    cmd_is_move = accept && is_move(cmd);
    cmd_dirs    = dirs_of(cmd);
    same_dir    = cmd_is_move && (cmd_dirs == {d1, d0});
    tick        = (state != ST_IDLE) && (timer == 16'd0);

    // Borrow out of bit 16 means the subtraction went below zero.
    dec_wide  = {1'b0, period} - {1'b0, P_DEC};
    period_dn = (dec_wide[16] || (dec_wide[15:0] < P_MIN)) ? P_MIN : dec_wide[15:0];
    inc_wide  = {1'b0, period} + {1'b0, P_DEC};
    period_up = (inc_wide > {1'b0, P_START}) ? P_START : inc_wide[15:0];
    period_run = (state == ST_ACCEL) ? period_dn : period;

    wdog_hit    = ((state == ST_ACCEL) || (state == ST_CRUISE)) && !accept &&
                  (wdog_cnt == WDOG_CYCLES);
    // A command arriving on the final deceleration tick still decides what follows.
    pending_eff = accept ? cmd : pending;
    decel_done  = (state == ST_DECEL) && tick && (period_up == P_START);
    start_move  = (state == ST_IDLE) && cmd_is_move;

    // Coils must be driven in any cycle whose next state is not IDLE.
    case (state)
      ST_IDLE:  run = start_move;
      ST_DECEL: run = !(decel_done && !is_move(pending_eff));
      default:  run = 1'b1;
    endcase
  end

  // Ramp FSM with step timer, period, pending command, watchdog and pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      period    <= P_START;
      timer     <= P_START - 16'd1;
      pending   <= CMD_NONE;
      wdog_cnt  <= 24'd0;
      d0        <= 1'b0;
      d1        <= 1'b0;
      cmd_err   <= 1'b0;
      wdog_trip <= 1'b0;
    end else begin
      cmd_err   <= cmd_bad;
      wdog_trip <= wdog_hit;

      if (accept || wdog_hit || (state == ST_IDLE) || (state == ST_DECEL))
        wdog_cnt <= 24'd0;
      else
        wdog_cnt <= wdog_cnt + 24'd1;

      if ((state != ST_IDLE) && !tick) timer <= timer - 16'd1;

      case (state)
        ST_IDLE: begin
          if (start_move) begin
            {d1, d0} <= cmd_dirs;
            period   <= P_START;
            timer    <= P_START - 16'd1;
            pending  <= CMD_NONE;
            state    <= ST_ACCEL;
          end
        end

        ST_ACCEL, ST_CRUISE: begin
          if (tick) begin
            period <= period_run;
            timer  <= period_run - 16'd1;
          end
          if (accept && !same_dir) begin
            pending <= cmd;
            state   <= ST_DECEL;
          end else if (wdog_hit) begin
            pending <= CMD_STOP;
            state   <= ST_DECEL;
          end else if ((state == ST_ACCEL) && tick && (period_dn == P_MIN)) begin
            state <= ST_CRUISE;
          end
        end

        ST_DECEL: begin
          if (accept) pending <= cmd;
          if (tick) begin
            period <= period_up;
            timer  <= period_up - 16'd1;
          end
          if (decel_done) begin
            pending <= CMD_NONE;
            if (is_move(pending_eff)) begin
              {d1, d0} <= dirs_of(pending_eff);
              state    <= ST_ACCEL;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign state_o = state;
  assign busy    = (state != ST_IDLE);

  halfstep_seq u_m0 (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .tick  (tick),
    .dir   (d0),
    .phase (m0_phase)
  );

  halfstep_seq u_m1 (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .tick  (tick),
    .dir   (d1),
    .phase (m1_phase)
  );

endmodule
